// File: rtl/csr_pkg.sv
// Shared encodings between the core-side trap sequencer and the machine CSR unit:
// CSR op codes, mcause values used as exception addresses, request kinds and sequencer states.
package csr_pkg;

  localparam logic [2:0] OP_EXCEPTION = 3'b000;
  localparam logic [2:0] OP_MRET      = 3'b001;
  localparam logic [2:0] OP_CSRRW     = 3'b101;
  localparam logic [2:0] OP_CSRRS     = 3'b110;
  localparam logic [2:0] OP_CSRRC     = 3'b111;

  localparam logic [4:0] MCAUSE_EXT_INT = 5'b11011;
  localparam logic [4:0] MCAUSE_SW_INT  = 5'b10011;
  localparam logic [4:0] MCAUSE_ILLEGAL = 5'b00010;

  typedef enum logic [1:0] {
    REQ_CSR  = 2'b00,
    REQ_MRET = 2'b01,
    REQ_EXC  = 2'b10,
    REQ_INT  = 2'b11
  } req_kind_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_DONE
  } state_t;

endpackage

// File: rtl/trap_sequencer.sv
// Sequences one system request at a time through the CSR unit handshake; done arrives four cycles
// after acceptance for a plain op (eight on the fault-reissue path). New requests wait while ready=0.
module trap_sequencer
  import csr_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [1:0]  req_kind,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_addr,
  input  logic [3:0]  exc_code,
  input  logic [31:0] operand,
  input  logic [31:0] pc,
  output logic        ready,
  output logic        done,
  output logic [31:0] result,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        trap_taken,
  output logic        error,
  output logic        csr_available,
  output logic [2:0]  csr_op,
  output logic [11:0] csr_addr_exception,
  output logic [31:0] csr_write_value,
  input  logic [31:0] csr_read_value,
  input  logic        csr_busy,
  input  logic        csr_fault,
  input  logic        csr_ext_int_pending,
  input  logic        csr_sw_int_pending
);

  localparam int WW = $clog2(TIMEOUT + 1);

  state_t         state;
  logic [WW-1:0]  wdog;
  logic           seen_busy;
  logic [31:0]    pc_q;

  logic           dec_issue;
  logic [2:0]     dec_op;
  logic [11:0]    dec_addr;
  logic [31:0]    dec_value;

  // Default decode is the illegal-instruction trap; legal kinds override it.
  always_comb begin
    dec_issue = 1'b1;
    dec_op    = OP_EXCEPTION;
    dec_addr  = {7'b0, MCAUSE_ILLEGAL};
    dec_value = pc;
    case (req_kind)
      REQ_CSR: begin
        if (funct3[1:0] != 2'b00) begin
          dec_op    = {1'b1, funct3[1:0]};
          dec_addr  = csr_addr;
          dec_value = operand;
        end
      end
      REQ_MRET: begin
        dec_op    = OP_MRET;
        dec_addr  = 12'h000;
        dec_value = 32'h0;
      end
      REQ_EXC: dec_addr = {8'b0, exc_code};
      REQ_INT: begin
        if (csr_ext_int_pending)     dec_addr = {7'b0, MCAUSE_EXT_INT};
        else if (csr_sw_int_pending) dec_addr = {7'b0, MCAUSE_SW_INT};
        else                         dec_issue = 1'b0;
      end
      default: dec_issue = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= S_IDLE;
      ready              <= 1'b1;
      done               <= 1'b0;
      result             <= '0;
      redirect           <= 1'b0;
      redirect_pc        <= '0;
      trap_taken         <= 1'b0;
      error              <= 1'b0;
      csr_available      <= 1'b0;
      csr_op             <= '0;
      csr_addr_exception <= '0;
      csr_write_value    <= '0;
      pc_q               <= '0;
      seen_busy          <= 1'b0;
      wdog               <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            ready              <= 1'b0;
            pc_q               <= pc;
            seen_busy          <= 1'b0;
            wdog               <= '0;
            csr_op             <= dec_op;
            csr_addr_exception <= dec_addr;
            csr_write_value    <= dec_value;
            if (dec_issue) begin
              state         <= S_ISSUE;
              csr_available <= 1'b1;
            end else begin
              state       <= S_DONE;
              done        <= 1'b1;
              result      <= '0;
              redirect    <= 1'b0;
              redirect_pc <= '0;
              trap_taken  <= 1'b0;
              error       <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          wdog <= wdog + 1'b1;
          if (csr_busy) seen_busy <= 1'b1;
          if (seen_busy && !csr_busy) begin
            csr_available <= 1'b0;
            if (csr_fault && csr_op[2]) begin
              // Faulting CSR access becomes an illegal-instruction trap after one idle cycle.
              state              <= S_GAP;
              csr_op             <= OP_EXCEPTION;
              csr_addr_exception <= {7'b0, MCAUSE_ILLEGAL};
              csr_write_value    <= pc_q;
            end else begin
              state       <= S_DONE;
              done        <= 1'b1;
              error       <= csr_fault;
              trap_taken  <= !csr_fault && (csr_op == OP_EXCEPTION);
              redirect    <= !csr_fault && !csr_op[2];
              redirect_pc <= (!csr_fault && !csr_op[2]) ? csr_read_value : '0;
              result      <= csr_op[2] ? csr_read_value : '0;
            end
          end else if (wdog == WW'(TIMEOUT - 1)) begin
            state         <= S_DONE;
            done          <= 1'b1;
            csr_available <= 1'b0;
            error         <= 1'b1;
            result        <= '0;
            redirect      <= 1'b0;
            redirect_pc   <= '0;
            trap_taken    <= 1'b0;
          end
        end
        S_GAP: begin
          state         <= S_ISSUE;
          csr_available <= 1'b1;
          wdog          <= '0;
          seen_busy     <= 1'b0;
        end
        S_DONE: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench with a CSR unit model; expected completions go into a scoreboard queue that a done-monitor drains.
module tb_trap_sequencer;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [1:0]  req_kind = 2'b00;
  logic [2:0]  funct3 = 3'b000;
  logic [11:0] csr_addr = 12'h000;
  logic [3:0]  exc_code = 4'h0;
  logic [31:0] operand = 32'h0;
  logic [31:0] pc = 32'h0;
  logic        ready, done, redirect, trap_taken, error, csr_available;
  logic [31:0] result, redirect_pc, csr_write_value;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr_exception;
  logic [31:0] csr_read_value = 32'h0;
  logic        csr_busy = 1'b0;
  logic        csr_fault = 1'b0;
  logic        csr_ext_int_pending = 1'b0;
  logic        csr_sw_int_pending = 1'b0;

  trap_sequencer #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .req(req), .req_kind(req_kind), .funct3(funct3),
    .csr_addr(csr_addr), .exc_code(exc_code), .operand(operand), .pc(pc),
    .ready(ready), .done(done), .result(result), .redirect(redirect),
    .redirect_pc(redirect_pc), .trap_taken(trap_taken), .error(error),
    .csr_available(csr_available), .csr_op(csr_op),
    .csr_addr_exception(csr_addr_exception), .csr_write_value(csr_write_value),
    .csr_read_value(csr_read_value), .csr_busy(csr_busy), .csr_fault(csr_fault),
    .csr_ext_int_pending(csr_ext_int_pending), .csr_sw_int_pending(csr_sw_int_pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // CSR unit model: busy in the 2nd cycle of available, response in the 3rd.
  logic never_busy = 1'b0;
  logic fault_csr  = 1'b0;
  logic fault_all  = 1'b0;
  int   acnt = 0;
  always @(negedge clk) begin
    int n;
    n = csr_available ? acnt + 1 : 0;
    acnt      <= n;
    csr_busy  <= !never_busy && (n == 2);
    csr_fault <= (n == 3) && (fault_all || (fault_csr && csr_op[2]));
  end

  typedef struct {
    int          acc;
    int          lat;
    logic [31:0] res;
    logic        rd;
    logic [31:0] rpc;
    logic        tr;
    logic        er;
  } exp_t;
  exp_t sb[$];

  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    prev_done <= done;
    if (done === 1'b1) begin
      chk("done_back_to_back", prev_done, 1'b0);
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc - e.acc, e.lat);
        chk("result", result, e.res);
        chk("redirect", redirect, e.rd);
        chk("redirect_pc", redirect_pc, e.rpc);
        chk("trap_taken", trap_taken, e.tr);
        chk("error", error, e.er);
      end
    end
  end

  task automatic send(input logic [1:0] k, input logic [2:0] f3, input logic [11:0] a,
                      input logic [3:0] ec, input logic [31:0] opd, input logic [31:0] p,
                      input logic ext, input logic sw, input bit expect_done, input int lat,
                      input logic [31:0] res, input logic rd, input logic [31:0] rpc,
                      input logic tr, input logic er);
    exp_t e;
    @(negedge clk);
    req = 1'b1; req_kind = k; funct3 = f3; csr_addr = a; exc_code = ec;
    operand = opd; pc = p; csr_ext_int_pending = ext; csr_sw_int_pending = sw;
    if (expect_done) begin
      e.acc = cyc; e.lat = lat; e.res = res; e.rd = rd; e.rpc = rpc; e.tr = tr; e.er = er;
      sb.push_back(e);
    end
    @(negedge clk);
    req = 1'b0; csr_ext_int_pending = 1'b0; csr_sw_int_pending = 1'b0;
  endtask

  task automatic wait_idle();
    int i = 0;
    while (ready !== 1'b1 && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk("ready_within_bound", ready, 1'b1);
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_req(input string name, input logic [2:0] op, input logic [11:0] a,
                         input logic [31:0] v);
    chk({name, "_avail"}, csr_available, 1'b1);
    chk({name, "_op"}, csr_op, op);
    chk({name, "_addr"}, csr_addr_exception, a);
    chk({name, "_value"}, csr_write_value, v);
  endtask

  initial begin
    skip(3);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_avail", csr_available, 1'b0);
    chk("rst_redirect", redirect, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_trap", trap_taken, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_op", csr_op, 3'b000);
    reset = 1'b0;

    // CSRRS 0x300 returns 0x88.
    csr_read_value = 32'h88;
    send(REQ_CSR, 3'b010, 12'h300, 4'h0, 32'h0, 32'h100, 0, 0, 1, 4, 32'h88, 0, 32'h0, 0, 0);
    chk_req("csrrs", OP_CSRRS, 12'h300, 32'h0);
    wait_idle();

    // CSRRW 0x341 faults, reissued as illegal-instruction trap to handler 0x10.
    csr_read_value = 32'h10;
    fault_csr = 1'b1;
    send(REQ_CSR, 3'b001, 12'h341, 4'h0, 32'hAAAA, 32'h200, 0, 0, 1, 8, 32'h0, 1, 32'h10, 1, 0);
    chk_req("csrrw", OP_CSRRW, 12'h341, 32'hAAAA);
    skip(3);
    chk("fault_gap_avail", csr_available, 1'b0);
    fault_csr = 1'b0;
    skip(1);
    chk_req("fault_reissue", OP_EXCEPTION, 12'h002, 32'h200);
    wait_idle();

    // Interrupt check, ext and sw pending: ext wins.
    csr_read_value = 32'h20;
    send(REQ_INT, 3'b000, 12'h0, 4'h0, 32'h0, 32'h400, 1, 1, 1, 4, 32'h0, 1, 32'h20, 1, 0);
    chk_req("int_ext", OP_EXCEPTION, 12'h01B, 32'h400);
    wait_idle();

    csr_read_value = 32'h24;
    send(REQ_INT, 3'b000, 12'h0, 4'h0, 32'h0, 32'h404, 0, 1, 1, 4, 32'h0, 1, 32'h24, 1, 0);
    chk_req("int_sw", OP_EXCEPTION, 12'h013, 32'h404);
    wait_idle();

    // Nothing pending: done in cycle 1, no CSR traffic.
    send(REQ_INT, 3'b000, 12'h0, 4'h0, 32'h0, 32'h408, 0, 0, 1, 1, 32'h0, 0, 32'h0, 0, 0);
    chk("int_none_avail", csr_available, 1'b0);
    wait_idle();

    csr_read_value = 32'h1234;
    send(REQ_MRET, 3'b000, 12'h0, 4'h0, 32'h0, 32'h500, 0, 0, 1, 4, 32'h0, 1, 32'h1234, 0, 0);
    chk("mret_op", csr_op, OP_MRET);
    wait_idle();

    csr_read_value = 32'h30;
    send(REQ_EXC, 3'b000, 12'h0, 4'hB, 32'h0, 32'h504, 0, 0, 1, 4, 32'h0, 1, 32'h30, 1, 0);
    chk_req("sync_exc", OP_EXCEPTION, 12'h00B, 32'h504);
    wait_idle();

    // funct3[1:0]=00 is illegal without touching the CSR.
    csr_read_value = 32'h40;
    send(REQ_CSR, 3'b100, 12'h300, 4'h0, 32'h5, 32'h600, 0, 0, 1, 4, 32'h0, 1, 32'h40, 1, 0);
    chk_req("illegal_f3", OP_EXCEPTION, 12'h002, 32'h600);
    wait_idle();

    csr_read_value = 32'h77;
    send(REQ_CSR, 3'b111, 12'h304, 4'h0, 32'h5, 32'h604, 0, 0, 1, 4, 32'h77, 0, 32'h0, 0, 0);
    chk_req("csrrc", OP_CSRRC, 12'h304, 32'h5);
    wait_idle();

    // Fault on an exception op is reported as error.
    fault_all = 1'b1;
    send(REQ_EXC, 3'b000, 12'h0, 4'h2, 32'h0, 32'h700, 0, 0, 1, 4, 32'h0, 0, 32'h0, 0, 1);
    wait_idle();
    fault_all = 1'b0;

    // CSR never raises busy: watchdog abandons.
    never_busy = 1'b1;
    send(REQ_CSR, 3'b001, 12'h305, 4'h0, 32'h9, 32'h800, 0, 0, 1, 9, 32'h0, 0, 32'h0, 0, 1);
    skip(7);
    chk("timeout_avail_c8", csr_available, 1'b1);
    skip(1);
    chk("timeout_avail_c9", csr_available, 1'b0);
    wait_idle();
    never_busy = 1'b0;

    // Reset in cycle 2 of an op: no done.
    csr_read_value = 32'h55;
    send(REQ_CSR, 3'b010, 12'h300, 4'h0, 32'h0, 32'h900, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    skip(1);
    reset = 1'b1;
    skip(1);
    chk("rst_mid_avail", csr_available, 1'b0);
    chk("rst_mid_ready", ready, 1'b1);
    reset = 1'b0;
    skip(6);

    csr_read_value = 32'h99;
    send(REQ_CSR, 3'b010, 12'h340, 4'h0, 32'h0, 32'h904, 0, 0, 1, 4, 32'h99, 0, 32'h0, 0, 0);
    wait_idle();

    skip(3);
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Core-side initiator for the machine-level CSR unit. Accepts one system request at a time from the execute stage: CSR instruction, MRET, synchronous exception, or instruction-boundary interrupt check. Drives the CSR unit's available/op/address/value handshake and returns the rd value or the PC redirect. A faulting CSR access is turned into an illegal-instruction trap.

## Interface
- `TIMEOUT`, 8: maximum cycles an operation may remain in ISSUE before it is abandoned.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req` in 1: request strobe; sampled only when `ready`=1.
- `req_kind` in 2: 00=CSR instr, 01=MRET, 10=sync exception, 11=interrupt check.
- `funct3` in 3: CSR instruction funct3.
- `csr_addr` in 12: CSR address.
- `exc_code` in 4: synchronous exception code.
- `operand` in 32: CSR write operand (rs1 or zero-extended uimm).
- `pc` in 32: PC of the current instruction.
- `ready` out 1: block is in IDLE.
- `done` out 1: one-cycle completion pulse.
- `result` out 32: rd value for CSR instructions.
- `redirect` out 1: `redirect_pc` is valid (qualified by `done`).
- `redirect_pc` out 32: next PC.
- `trap_taken` out 1: an exception op was issued.
- `error` out 1: timeout abandon (qualified by `done`).
- `csr_available`, `csr_op`[3], `csr_addr_exception`[12], `csr_write_value`[32] out: CSR unit request.
- `csr_read_value`[32], `csr_busy`, `csr_fault`, `csr_ext_int_pending`, `csr_sw_int_pending` in: CSR unit response.

## Operation
- States: IDLE, ISSUE, GAP, DONE.
- Reset (sync): state=IDLE. All outputs 0 except `ready`=1. Captured request registers cleared.
- IDLE with `req`=1: latch the inputs, decode, and either go to ISSUE or go straight to DONE.
  - CSR instr, funct3[1:0]≠00: op={1,funct3[1:0]}, addr=csr_addr, value=operand.
  - CSR instr, funct3[1:0]=00: illegal. Issue exception op 000 with addr 12'h002, value=pc.
  - MRET: op 001. Result is redirect to `csr_read_value` (mepc).
  - Sync exception: op 000, addr={8'b0,0,exc_code}, value=pc.
  - Interrupt check, priority ext > sw:
    - ext pending: addr 12'h01B.
    - sw pending: addr 12'h013.
    - neither: go directly to DONE with redirect=0 and trap_taken=0.
- Every exception op completes with redirect=1 and redirect_pc=`csr_read_value` (handler).
- ISSUE: hold `csr_available`=1 with op/addr/value stable. Wait for `csr_busy` rise then fall. In the fall cycle, sample `csr_read_value` and `csr_fault`.
  - No fault: go to DONE. For a CSR instr, result=read_value and redirect=0.
  - Fault on a CSR instr: go to GAP, reload with illegal exception (op 000, addr 12'h002, value=pc), then return to ISSUE.
  - Fault on op 000/001 cannot occur; if it does, treat as error.
- GAP: `csr_available`=0 for exactly one cycle. This lets the CSR unit's start flag clear.
- DONE: `done`=1, `csr_available`=0. Next cycle is IDLE.
- Watchdog: a counter clears on entry to ISSUE. On reaching TIMEOUT: go to DONE with `error`=1, redirect=0, and drop available.
- Reset mid-operation: abort immediately. `csr_available`=0 the next cycle; no `done`.

## Timing
- Single CSR op, `req` accepted in cycle 0:
  - `csr_available` 1 in cycles 1–3.
  - `csr_busy` high in cycle 2, low in cycle 3 (sample).
  - `done` in cycle 4; `ready` in cycle 5.
- Fault path: GAP in cycle 4, reissue in cycle 5, busy in cycle 6, sample in cycle 7, `done` in cycle 8.
- Interrupt check with nothing pending: `done` in cycle 1.
- Pending inputs are sampled only in the acceptance cycle.
- `csr_available` is never low for fewer than one cycle between consecutive ops.
- `done` is never asserted back-to-back.

## Structure
- Shared package `csr_pkg`:
  - CSR op encodings (EXCEPTION, MRET, CSRRW/RS/RC).
  - mcause codes: EXT_INT 5'b11011, SW_INT 5'b10011, ILLEGAL 5'b00010.
  - `req_kind` enum and state enum.
- Single module, no sub-module. Decode logic and watchdog live inline.

## Test plan
- CSRRS, addr 12'h300, operand 0, CSR returns 32'h88: `done` in cycle 4, result=32'h88, redirect=0.
- CSRRW to 12'h341, CSR faults: exception reissued in cycle 5 with addr 12'h002 and value=pc. `done` in cycle 8, trap_taken=1, redirect_pc=handler 32'h10.
- Interrupt check with ext and sw both pending, pc=32'h400: op 000, addr 12'h01B, write_value=32'h400 (ext wins).
- MRET, CSR read_value 32'h1234: redirect=1, redirect_pc=32'h1234, trap_taken=0.
- CSR model never raises busy, TIMEOUT=8: `done`+`error` 9 cycles after issue, `csr_available` drops.
- Reset asserted in cycle 2 of an op: cycle 3 has `csr_available`=0 and `ready`=1; no `done` pulse.
